imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Writer side of the instruction-memory fetch interface. Receives a byte-serial program image and assembles it into 32-bit big-endian words.
- Writes each word into the instruction memory write port.
- Holds the pipeline in reset (cpu_hold) until a complete image has loaded without error.
- Sits between the board-level UART/host byte stream and the instruction memory, beside the pipeline top level.

Parameters:
- DEPTH_WORDS, 128, instruction memory capacity in 32-bit words
- BASE_ADDR, 32'h0000_0000, byte address of the first image word
- CNT_W, 8, width of the word counter; must satisfy 2^CNT_W > DEPTH_WORDS

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  begin a new load; honoured only in IDLE, DONE or ERROR
- s_valid  in  1  byte-stream data valid
- s_ready  out  1  loader can accept a byte
- s_data  in  8  image byte
- s_last  in  1  marks the final byte of the image (qualified by s_valid && s_ready)
- busy  out  1  load in progress (LOAD or WRITE)
- done  out  1  image loaded successfully; sticky until next start
- error  out  1  load failed; sticky until next start
- cpu_hold  out  1  1 = keep pipeline in reset
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  32  byte address of the word being written
- imem_wdata  out  32  assembled word
- words_loaded  out  CNT_W  words written in the current load

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; byte_idx=0; word_cnt=0; shift register=0.
  - s_ready=0, busy=0, done=0, error=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, words_loaded=0.
  - cpu_hold=1.
  - Reset mid-load abandons the partial word; words already written stay in memory.
- Handshake: a byte transfers on the rising edge where s_valid && s_ready. s_ready is a registered output, high only in LOAD.
- States:
  - IDLE: on start -> LOAD. Clear byte_idx, word_cnt, done and error. cpu_hold=1.
  - LOAD: s_ready=1, busy=1.
    - Each accepted byte shifts in MSB-first: byte 0 goes to [31:24], byte 3 to [7:0]. byte_idx increments mod 4.
    - On the 4th byte: if word_cnt==DEPTH_WORDS -> ERROR (overflow, no write); else -> WRITE.
    - s_last accepted with byte_idx!=3 -> ERROR (misaligned image, partial word discarded).
    - start is ignored.
  - WRITE: one cycle; s_ready=0.
    - imem_we=1, imem_addr=BASE_ADDR+4*word_cnt, imem_wdata=assembled word.
    - word_cnt++ and words_loaded updates on the same edge.
    - Next state is DONE if the 4th byte carried s_last, else LOAD.
  - DONE: done=1, busy=0, cpu_hold=0 (registered; deasserts the cycle after entry). On start -> LOAD, with cpu_hold=1 on the next cycle.
  - ERROR: error=1, busy=0, cpu_hold=1. On start -> LOAD.
- Latency: imem_we asserts on the cycle after the 4th byte is accepted. Sustained throughput is 4 bytes per 5 cycles.
- Boundary: an image of exactly DEPTH_WORDS words succeeds. One byte beyond that is not accepted as a write; the state goes to ERROR when its word completes, or earlier if s_last makes it misaligned.
- start together with s_valid in IDLE: that byte is not accepted, because s_ready is 0 in IDLE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - The byte flagged s_last is a checksum byte, not image data. It must arrive with byte_idx==0; otherwise -> ERROR.
  - A running 8-bit sum covers all image bytes. If sum + checksum != 8'h00 -> ERROR. Written words remain in memory and cpu_hold stays 1.
  - On match -> DONE directly from LOAD.
- When undefined: no checksum logic; s_last marks the last data byte, as described above.

Test Plan:
- Reset low 3 cycles -> cpu_hold=1, all other outputs 0, imem_addr=BASE_ADDR.
- start, then bytes 20,08,00,05,00,00,00,00 with s_last on the last byte -> writes 32'h2008_0005 @0x0 and 32'h0000_0000 @0x4; done=1, words_loaded=2, cpu_hold=0 one cycle later.
- s_valid toggled randomly during the same 8-byte load -> identical writes; exactly one imem_we per word; no byte lost or duplicated.
- s_last on the 6th byte -> one write only, then error=1, cpu_hold=1; a fresh start and a valid image -> done=1.
- DEPTH_WORDS=4: load 16 bytes with s_last -> done. Load 20 bytes -> 4 writes then error=1, no write to address 0x10.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01,02,03,04 then checksum F6 with s_last -> done. The same image with checksum F7 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a byte-serial program image, packs it MSB-first into 32-bit
// big-endian words and writes each word into the instruction memory.
// Holds the CPU pipeline in reset (cpu_hold) until an image has loaded cleanly.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, the byte flagged s_last is a checksum byte, not image data.
//   It must arrive on a word boundary, and the 8-bit sum of all image bytes
//   plus the checksum must be 8'h00. Otherwise the load ends in ERROR.
//
// Byte handshake: a byte moves on the rising clk edge where s_valid && s_ready.
// s_ready is registered and is high only while the FSM is in LOAD. s_last is
// meaningful only on a cycle where that transfer happens.
module imem_boot_loader #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_hold,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_cnt;
  logic [23:0]      shift_q;    // first three bytes of the word in progress
  logic             last_q;     // the byte that completed this word carried s_last
  logic             xfer;
  logic             start_ok;
  logic             word_full;

  // s_ready is only ever high in LOAD, so xfer implies state == ST_LOAD.
  assign xfer      = s_valid && s_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                               (state == ST_ERROR));
  assign word_full = (word_cnt == CNT_W'(DEPTH_WORDS));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  assign sum_chk = sum_q + s_data;
`endif

  // Next-state logic: start, byte arrival, word completion and image end.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (s_last) begin
            // Checksum byte: must sit on a word boundary and zero the sum.
            if ((byte_idx == 2'd0) && (sum_chk == 8'h00)) state_nxt = ST_DONE;
            else                                          state_nxt = ST_ERROR;
          end else if (byte_idx == 2'd3) begin
            state_nxt = word_full ? ST_ERROR : ST_WRITE;
          end
`else
          if (s_last && (byte_idx != 2'd3)) begin
            // Image ends mid-word: the partial word is dropped.
            state_nxt = ST_ERROR;
          end else if (byte_idx == 2'd3) begin
            state_nxt = word_full ? ST_ERROR : ST_WRITE;
          end
`endif
        end
      end
      ST_WRITE: begin
        state_nxt = last_q ? ST_DONE : ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      byte_idx     <= 2'd0;
      word_cnt     <= '0;
      shift_q      <= 24'd0;
      last_q       <= 1'b0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == ST_LOAD);
      busy    <= (state_nxt == ST_LOAD) || (state_nxt == ST_WRITE);
      done    <= (state_nxt == ST_DONE);
      error   <= (state_nxt == ST_ERROR);
      imem_we <= (state_nxt == ST_WRITE);
      // Release the pipeline one cycle after DONE is entered; re-hold it as
      // soon as a new load starts.
      cpu_hold <= !((state == ST_DONE) && (state_nxt == ST_DONE));

      if (start_ok) begin
        byte_idx     <= 2'd0;
        word_cnt     <= '0;
        words_loaded <= '0;
        shift_q      <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q        <= 8'h00;
`endif
      end

      if (xfer) begin
        shift_q  <= {shift_q[15:0], s_data};
        byte_idx <= byte_idx + 2'd1;
        last_q   <= s_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q    <= sum_chk;
`endif
      end

      if ((state == ST_LOAD) && (state_nxt == ST_WRITE)) begin
        imem_wdata <= {shift_q, s_data};
        imem_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
      end

      if (state == ST_WRITE) begin
        word_cnt     <= word_cnt + 1'b1;
        words_loaded <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Drives byte images (directed and $urandom) into imem_boot_loader with a
// small DEPTH_WORDS so the capacity boundary is reachable, and compares the
// memory writes and final status against a word-level reference model.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CW    = 8;
  localparam int OC_LOAD = 0;
  localparam int OC_DONE = 1;
  localparam int OC_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready, busy, done, error, cpu_hold, imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] words_loaded;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int wr_seen   = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  img[$];

  imem_boot_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_hold    (cpu_hold),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .words_loaded(words_loaded)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every memory write is matched against the expected queue.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      wr_seen++;
      if (exp_q.size() != 0) check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  // Reference model: image bytes -> expected writes, final outcome, word count.
  task automatic model_load(input logic [7:0] b[$], input int last_at,
                            output int oc, output int nw);
    int n;
    logic [7:0]  sum;
    logic [31:0] word;
    oc  = OC_LOAD;
    nw  = 0;
    sum = 8'h00;
    n   = b.size();
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (last_at >= 0) n = last_at;
`endif
    for (int w = 0; 4 * w + 3 < n; w++) begin
      if (w >= int'(DEPTH)) begin
        oc = OC_ERR;
        break;
      end
      word = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      exp_q.push_back({BASE + 32'(4 * w), word});
      nw++;
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (last_at == 4 * w + 3) begin
        oc = OC_DONE;
        break;
      end
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (oc == OC_LOAD && last_at >= 0) begin
      for (int k = 0; k < n; k++) sum += b[k];
      sum += b[last_at];
      oc = ((n % 4 == 0) && (sum == 8'h00)) ? OC_DONE : OC_ERR;
    end
`else
    if (oc == OC_LOAD && last_at >= 0) oc = OC_ERR;
`endif
  endtask

  // Driver: start pulse, with a stray byte that must not be accepted.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Driver: stream bytes, optionally with random gaps in s_valid.
  task automatic send_bytes(input logic [7:0] b[$], input int last_at, input bit rnd);
    int i;
    int guard;
    bit go;
    i = 0; guard = 0; go = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      if (go) i++;
      if (i >= b.size()) break;
      if (guard > 400) begin
        check("send_timeout", 64'(i), 64'(b.size()));
        break;
      end
      guard++;
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s_valid) begin
        s_data = b[i];
        s_last = (i == last_at);
      end else begin
        s_data = 8'($urandom_range(0, 255));
        s_last = 1'($urandom_range(0, 1));
      end
      go = s_valid && s_ready;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // One full load: model, drive, then check final status and write count.
  task automatic run_load(input string tag, input logic [7:0] b[$], input int last_at, input bit rnd);
    int oc, nw, guard;
    bit seen;
    exp_q.delete();
    wr_seen = 0;
    model_load(b, last_at, oc, nw);
    do_start();
    send_bytes(b, last_at, rnd);
    if (oc != OC_LOAD) begin
      guard = 0;
      seen  = done || error;
      while (!seen && guard < 40) begin
        @(negedge clk);
        guard++;
        seen = done || error;
      end
      check({tag, ":finished"}, 64'(seen), 64'd1);
      check({tag, ":done"}, 64'(done), 64'(oc == OC_DONE));
      check({tag, ":error"}, 64'(error), 64'(oc == OC_ERR));
      check({tag, ":words_loaded"}, 64'(words_loaded), 64'(nw));
      check({tag, ":busy"}, 64'(busy), 64'd0);
      check({tag, ":s_ready"}, 64'(s_ready), 64'd0);
      check({tag, ":hold_at_entry"}, 64'(cpu_hold), 64'd1);
      @(negedge clk);
      check({tag, ":hold_after"}, 64'(cpu_hold), 64'(oc != OC_DONE));
      check({tag, ":write_count"}, 64'(wr_seen), 64'(nw));
      check({tag, ":writes_pending"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    // Reset block
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst:s_ready", 64'(s_ready), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:error", 64'(error), 64'd0);
    check("rst:imem_we", 64'(imem_we), 64'd0);
    check("rst:imem_addr", 64'(imem_addr), 64'(BASE));
    check("rst:imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst:words_loaded", 64'(words_loaded), 64'd0);
    rst = 1'b1;

`ifndef IMEM_LOADER_CHECKSUM_EN
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load("basic", img, 7, 1'b0);
    run_load("basic_rnd", img, 7, 1'b1);
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h22};
    run_load("misalign", img, 5, 1'b1);
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_load("recover", img, 7, 1'b0);
    img.delete();
    for (int k = 0; k < 16; k++) img.push_back(8'($urandom_range(0, 255)));
    run_load("full_depth", img, 15, 1'b1);
    for (int k = 0; k < 4; k++) img.push_back(8'($urandom_range(0, 255)));
    run_load("overflow", img, 19, 1'b0);
    for (int t = 0; t < 6; t++) begin
      int nb;
      img.delete();
      nb = 4 * $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) img.push_back(8'($urandom_range(0, 255)));
      run_load("rand", img, nb - 1, 1'b1);
    end
`else
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    run_load("ck_ok", img, 4, 1'b0);
    img[4] = 8'hF7;
    run_load("ck_bad", img, 4, 1'b1);
    for (int t = 0; t < 6; t++) begin
      int nd;
      logic [7:0] sum;
      img.delete();
      sum = 8'h00;
      nd = 4 * $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) nd = nd + 2;
      for (int k = 0; k < nd; k++) begin
        img.push_back(8'($urandom_range(0, 255)));
        sum += img[k];
      end
      sum = -sum;
      if ($urandom_range(0, 2) == 0) sum = sum + 8'($urandom_range(1, 255));
      img.push_back(sum);
      run_load("ck_rand", img, nd, 1'b1);
    end
`endif

    // Reset in the middle of a load: one word written, then abandoned.
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_load("midload", img, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("midload:words_loaded", 64'(words_loaded), 64'd1);
    check("midload:busy", 64'(busy), 64'd1);
    check("midload:write_count", 64'(wr_seen), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst:cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:s_ready", 64'(s_ready), 64'd0);
    check("midrst:words_loaded", 64'(words_loaded), 64'd0);
    rst = 1'b1;
`ifndef IMEM_LOADER_CHECKSUM_EN
    img = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_load("after_rst", img, 3, 1'b1);
`else
    img = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00};
    img[4] = -(img[0] + img[1] + img[2] + img[3]);
    run_load("after_rst", img, 4, 1'b1);
`endif

    // Final report
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
